// File: rtl/bus_datapath_gen_if.sv
// -----------------------------------------------------------------------------
// bus_datapath_gen_if
//
// Purpose: bundles the control-step and memory-side signals of the parametrised
// single-bus datapath. The control sequencer and memory interface drive it as
// master. The datapath core consumes it as slave.
//
// Parameters:
//   WIDTH  data / bus width in bits
//   NREGS  number of general registers
//
// Signals (direction as seen from the slave / datapath):
//   Mdatain     in   WIDTH        memory read data
//   MemReady    in   1            memory data valid
//   Read        in   1            with MDRin: select memory as MDR source
//   MDRin       in   1            MDR load enable
//   MDRout      in   1            MDR drives bus
//   Rin         in   NREGS        per-register load enable, from bus
//   Rout        in   NREGS        per-register bus drive enable
//   ExtIn       in   WIDTH        external bus value
//   ExtOut      in   1            ExtIn drives bus
//   BusMuxOut   out  WIDTH        current bus value (combinational)
//   RegView     out  NREGS*WIDTH  all registers, R0 in the low WIDTH bits
//   MDRq        out  WIDTH        MDR contents
//   MemBusy     out  1            memory read in progress
//   Done        out  1            one-cycle pulse, MDR loaded from memory
//   MemErr      out  1            sticky, memory read timed out
//   BusConflict out  1            sticky, more than one bus driver at an edge
// -----------------------------------------------------------------------------
interface bus_datapath_gen_if #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16
);
    logic [WIDTH-1:0]       Mdatain;
    logic                   MemReady;
    logic                   Read;
    logic                   MDRin;
    logic                   MDRout;
    logic [NREGS-1:0]       Rin;
    logic [NREGS-1:0]       Rout;
    logic [WIDTH-1:0]       ExtIn;
    logic                   ExtOut;

    logic [WIDTH-1:0]       BusMuxOut;
    logic [NREGS*WIDTH-1:0] RegView;
    logic [WIDTH-1:0]       MDRq;
    logic                   MemBusy;
    logic                   Done;
    logic                   MemErr;
    logic                   BusConflict;

    // Sequencer / memory side
    modport master (
        output Mdatain, MemReady, Read, MDRin, MDRout, Rin, Rout, ExtIn, ExtOut,
        input  BusMuxOut, RegView, MDRq, MemBusy, Done, MemErr, BusConflict
    );

    // Datapath side
    modport slave (
        input  Mdatain, MemReady, Read, MDRin, MDRout, Rin, Rout, ExtIn, ExtOut,
        output BusMuxOut, RegView, MDRq, MemBusy, Done, MemErr, BusConflict
    );
endinterface

// File: rtl/bus_datapath_gen.sv
// -----------------------------------------------------------------------------
// bus_datapath_gen
//
// Purpose: parametrised single-bus datapath core. NREGS general registers and
// a memory data register (MDR) share one bus built by a priority multiplexer
// (Rout[0] highest, then higher Rout indices, then MDRout, then ExtOut).
// The MDR loads either from the bus in one edge or from memory through a
// two-state wait-state read handshake with a timeout abort.
//
// Parameters:
//   WIDTH    data / bus width in bits
//   NREGS    number of general registers (2..32)
//   TIMEOUT  maximum WAIT-state edges before a memory read aborts (>=1)
//
// Ports:
//   clk   in  rising-edge clock
//   rst   in  asynchronous, active-high clear
//   bus   bus_datapath_gen_if.slave, all control, data and status signals
// -----------------------------------------------------------------------------
module bus_datapath_gen #(
    parameter int WIDTH   = 32,
    parameter int NREGS   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    bus_datapath_gen_if.slave   bus
);

    localparam int             CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam int             DRV_W    = NREGS + 2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    logic [WIDTH-1:0] reg_q [NREGS];
    logic [WIDTH-1:0] reg_d [NREGS];
    logic [WIDTH-1:0] mdr_q, mdr_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             conf_q, conf_d;

    logic [WIDTH-1:0] bus_val;
    logic [DRV_W-1:0] drv;
    logic             multi_drv;

    // All bus drive enables, register enables in the low bits.
    assign drv = {bus.ExtOut, bus.MDRout, bus.Rout};

    // x & (x-1) clears the lowest set bit, so anything left means two or more drivers.
    assign multi_drv = |(drv & (drv - DRV_W'(1)));

    // Bus multiplexer: sources are applied from lowest to highest priority so
    // the last assignment that fires (the lowest enabled index) wins.
    always_comb begin
        bus_val = '0;
        if (bus.ExtOut) begin
            bus_val = bus.ExtIn;
        end
        if (bus.MDRout) begin
            bus_val = mdr_q;
        end
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (bus.Rout[i]) begin
                bus_val = reg_q[i];
            end
        end
    end

    // General registers: each one independently captures the bus when its Rin bit is set.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            reg_d[i] = bus.Rin[i] ? bus_val : reg_q[i];
        end
    end

    // Memory-read FSM and MDR source selection. While a read is pending the
    // MDR ignores MDRin entirely. The counter tracks WAIT edges without
    // MemReady, and the edge that finds it at TIMEOUT-1 aborts the read.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mdr_d   = mdr_q;
        done_d  = 1'b0;
        err_d   = err_q;
        conf_d  = conf_q | multi_drv;

        case (state_q)
            S_IDLE: begin
                if (bus.MDRin) begin
                    if (bus.Read) begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end else begin
                        mdr_d = bus_val;
                    end
                end
            end
            S_WAIT: begin
                if (bus.MemReady) begin
                    mdr_d   = bus.Mdatain;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Register bank flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                reg_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                reg_q[i] <= reg_d[i];
            end
        end
    end

    // MDR, FSM state and status flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mdr_q   <= '0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            conf_q  <= 1'b0;
        end else begin
            mdr_q   <= mdr_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            conf_q  <= conf_d;
        end
    end

    // Flattened register view, R0 in the least significant slice.
    for (genvar g = 0; g < NREGS; g++) begin : g_view
        assign bus.RegView[g*WIDTH +: WIDTH] = reg_q[g];
    end

    assign bus.BusMuxOut   = bus_val;
    assign bus.MDRq        = mdr_q;
    assign bus.MemBusy     = (state_q == S_WAIT);
    assign bus.Done        = done_q;
    assign bus.MemErr      = err_q;
    assign bus.BusConflict = conf_q;

endmodule

// File: tb/tb_bus_datapath_gen.sv
// -----------------------------------------------------------------------------
// tb_bus_datapath_gen
//
// Purpose: self-checking bench for bus_datapath_gen. Instance A uses
// WIDTH=32, NREGS=16, TIMEOUT=15. Instance B uses WIDTH=16, NREGS=4 to
// exercise parametrisation and RegView packing. A behavioural model tracks
// instance A for the randomized phase.
// -----------------------------------------------------------------------------
module tb_bus_datapath_gen;

    localparam int W  = 32;
    localparam int N  = 16;
    localparam int TO = 15;
    localparam int WB = 16;
    localparam int NB = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bus_datapath_gen_if #(.WIDTH(W),  .NREGS(N))  ifA ();
    bus_datapath_gen_if #(.WIDTH(WB), .NREGS(NB)) ifB ();

    bus_datapath_gen #(.WIDTH(W), .NREGS(N), .TIMEOUT(TO)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (ifA)
    );

    bus_datapath_gen #(.WIDTH(WB), .NREGS(NB), .TIMEOUT(TO)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (ifB)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model of instance A
    logic [W-1:0] mReg [N];
    logic [W-1:0] mMdr;
    bit           mBusy;
    int           mWaited;
    bit           mDone;
    bit           mErr;
    bit           mConf;

    typedef struct {
        logic [N-1:0] rin;
        logic [N-1:0] rout;
        logic         mdrin;
        logic         mdrout;
        logic         read;
        logic         extout;
        logic         memready;
        logic [W-1:0] extin;
        logic [W-1:0] mdatain;
        logic [W-1:0] expBus;
        logic [W-1:0] expMdr;
        logic         expBusy;
        logic         expDone;
        logic         expErr;
        logic         expConf;
        int           regIdx;
        logic [W-1:0] expReg;
        string        name;
    } vec_t;

    vec_t vecs [9];

    task automatic checkOutput(input string name, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic clearInputs();
        ifA.Mdatain = '0; ifA.MemReady = 1'b0; ifA.Read = 1'b0; ifA.MDRin = 1'b0;
        ifA.MDRout = 1'b0; ifA.Rin = '0; ifA.Rout = '0; ifA.ExtIn = '0; ifA.ExtOut = 1'b0;
        ifB.Mdatain = '0; ifB.MemReady = 1'b0; ifB.Read = 1'b0; ifB.MDRin = 1'b0;
        ifB.MDRout = 1'b0; ifB.Rin = '0; ifB.Rout = '0; ifB.ExtIn = '0; ifB.ExtOut = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        ifA.Rin = v.rin; ifA.Rout = v.rout; ifA.MDRin = v.mdrin; ifA.MDRout = v.mdrout;
        ifA.Read = v.read; ifA.ExtOut = v.extout; ifA.MemReady = v.memready;
        ifA.ExtIn = v.extin; ifA.Mdatain = v.mdatain;
    endtask

    task automatic modelReset();
        for (int i = 0; i < N; i++) mReg[i] = '0;
        mMdr = '0; mBusy = 0; mWaited = 0; mDone = 0; mErr = 0; mConf = 0;
    endtask

    function automatic logic [W-1:0] modelBus();
        for (int i = 0; i < N; i++) begin
            if (ifA.Rout[i]) return mReg[i];
        end
        if (ifA.MDRout) return mMdr;
        if (ifA.ExtOut) return ifA.ExtIn;
        return '0;
    endfunction

    // Advances the model by one rising edge using the inputs currently applied.
    task automatic modelEdge();
        logic [W-1:0] b;
        int drivers;
        b = modelBus();
        drivers = $countones({ifA.ExtOut, ifA.MDRout, ifA.Rout});
        if (drivers >= 2) mConf = 1;
        for (int i = 0; i < N; i++) begin
            if (ifA.Rin[i]) mReg[i] = b;
        end
        mDone = 0;
        if (!mBusy) begin
            if (ifA.MDRin && ifA.Read) begin
                mBusy = 1;
                mWaited = 0;
            end else if (ifA.MDRin) begin
                mMdr = b;
            end
        end else begin
            mWaited++;
            if (ifA.MemReady) begin
                mMdr = ifA.Mdatain;
                mDone = 1;
                mBusy = 0;
            end else if (mWaited == TO) begin
                mBusy = 0;
                mErr = 1;
            end
        end
    endtask

    task automatic tick();
        modelEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic checkModel(input string tag);
        logic [N*W-1:0] view;
        for (int i = 0; i < N; i++) view[i*W +: W] = mReg[i];
        checkOutput({tag, ".bus"},      ifA.BusMuxOut,   modelBus());
        checkOutput({tag, ".regview"},  ifA.RegView,     view);
        checkOutput({tag, ".mdr"},      ifA.MDRq,        mMdr);
        checkOutput({tag, ".busy"},     ifA.MemBusy,     mBusy);
        checkOutput({tag, ".done"},     ifA.Done,        mDone);
        checkOutput({tag, ".err"},      ifA.MemErr,      mErr);
        checkOutput({tag, ".conflict"}, ifA.BusConflict, mConf);
    endtask

    // Asserts Clear in the middle of a cycle, checks the asynchronous effect,
    // releases it on the falling edge and steps one clean edge.
    task automatic doClear(input string tag);
        clearInputs();
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checkModel(tag);
        checkOutput({tag, ".busy0"}, ifA.MemBusy, 1'b0);
        checkOutput({tag, ".done0"}, ifA.Done,    1'b0);
        checkOutput({tag, ".err0"},  ifA.MemErr,  1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        vecs[0] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h12,
                    32'h0,  32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 3, 32'h0,  "read_req"};
        vecs[1] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  32'h12,
                    32'h0,  32'h12, 1'b0, 1'b1, 1'b0, 1'b0, 3, 32'h0,  "read_done"};
        vecs[2] = '{16'h0008, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,
                    32'h12, 32'h12, 1'b0, 1'b0, 1'b0, 1'b0, 3, 32'h12, "mdr_to_r3"};
        vecs[3] = '{16'h0002, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA,  32'h0,
                    32'hA,  32'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1, 32'hA,  "ext_to_r1"};
        vecs[4] = '{16'h0004, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hB,  32'h0,
                    32'hB,  32'h12, 1'b0, 1'b0, 1'b0, 1'b0, 2, 32'hB,  "ext_to_r2"};
        vecs[5] = '{16'h0010, 16'h0006, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h77, 32'h0,
                    32'hA,  32'h12, 1'b0, 1'b0, 1'b0, 1'b1, 4, 32'hA,  "priority_conflict"};
        vecs[6] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,
                    32'h0,  32'h12, 1'b0, 1'b0, 1'b0, 1'b1, 3, 32'h12, "conflict_sticky"};
        vecs[7] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,
                    32'h12, 32'h12, 1'b0, 1'b0, 1'b0, 1'b1, 4, 32'hA,  "mdr_self_reload"};
        vecs[8] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h5A, 32'h0,
                    32'h5A, 32'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1, 32'hA,  "ext_to_mdr"};

        rst = 1'b1;
        clearInputs();
        modelReset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] reset / idle");
        doClear("reset");
        checkModel("post_reset");

        $display("[TB] table vectors");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput({vecs[i].name, ".bus"}, ifA.BusMuxOut, vecs[i].expBus);
            tick();
            checkOutput({vecs[i].name, ".mdr"},      ifA.MDRq,        vecs[i].expMdr);
            checkOutput({vecs[i].name, ".busy"},     ifA.MemBusy,     vecs[i].expBusy);
            checkOutput({vecs[i].name, ".done"},     ifA.Done,        vecs[i].expDone);
            checkOutput({vecs[i].name, ".err"},      ifA.MemErr,      vecs[i].expErr);
            checkOutput({vecs[i].name, ".conflict"}, ifA.BusConflict, vecs[i].expConf);
            checkOutput({vecs[i].name, ".reg"}, ifA.RegView[vecs[i].regIdx*W +: W], vecs[i].expReg);
        end
        clearInputs();

        $display("[TB] wait states");
        ifA.MDRin = 1'b1; ifA.Read = 1'b1;
        tick();
        checkOutput("ws.req_busy", ifA.MemBusy, 1'b1);
        clearInputs();
        ifA.Mdatain = 32'h34;
        for (int i = 1; i <= 2; i++) begin
            tick();
            checkOutput("ws.wait_busy", ifA.MemBusy, 1'b1);
            checkOutput("ws.wait_mdr",  ifA.MDRq,    32'h5A);
            checkOutput("ws.wait_done", ifA.Done,    1'b0);
        end
        ifA.MemReady = 1'b1;
        tick();
        checkOutput("ws.k3_mdr",  ifA.MDRq,    32'h34);
        checkOutput("ws.k3_done", ifA.Done,    1'b1);
        checkOutput("ws.k3_busy", ifA.MemBusy, 1'b0);
        clearInputs();
        tick();
        checkOutput("ws.done_clears", ifA.Done, 1'b0);

        $display("[TB] timeout");
        ifA.MDRin = 1'b1; ifA.Read = 1'b1;
        tick();
        clearInputs();
        ifA.Mdatain = 32'h99;
        for (int i = 1; i < TO; i++) begin
            tick();
            checkOutput("to.busy", ifA.MemBusy, 1'b1);
            checkOutput("to.err",  ifA.MemErr,  1'b0);
            checkOutput("to.done", ifA.Done,    1'b0);
        end
        tick();
        checkOutput("to.abort_busy", ifA.MemBusy, 1'b0);
        checkOutput("to.abort_err",  ifA.MemErr,  1'b1);
        checkOutput("to.abort_done", ifA.Done,    1'b0);
        checkOutput("to.abort_mdr",  ifA.MDRq,    32'h34);
        tick();
        checkOutput("to.err_sticky", ifA.MemErr, 1'b1);

        $display("[TB] busy and abort");
        ifA.MDRin = 1'b1; ifA.Read = 1'b1;
        tick();
        ifA.Read = 1'b0; ifA.ExtOut = 1'b1; ifA.ExtIn = 32'h55;
        #1;
        checkOutput("busy.bus_ext", ifA.BusMuxOut, 32'h55);
        tick();
        checkOutput("busy.mdr_kept",   ifA.MDRq,    32'h34);
        checkOutput("busy.still_busy", ifA.MemBusy, 1'b1);
        ifA.Read = 1'b1; ifA.ExtOut = 1'b0;
        tick();
        checkOutput("busy.req_ignored", ifA.MemBusy, 1'b1);
        doClear("abort");
        ifA.MemReady = 1'b1; ifA.Mdatain = 32'hFF;
        tick();
        checkOutput("abort.no_done", ifA.Done, 1'b0);
        checkOutput("abort.mdr",     ifA.MDRq, 32'h0);
        clearInputs();

        $display("[TB] parametrised instance");
        ifB.Mdatain = 16'hBEEF; ifB.MDRin = 1'b1; ifB.Read = 1'b1;
        tick();
        ifB.MDRin = 1'b0; ifB.Read = 1'b0; ifB.MemReady = 1'b1;
        tick();
        checkOutput("b.mdr",  ifB.MDRq, 16'hBEEF);
        checkOutput("b.done", ifB.Done, 1'b1);
        ifB.MemReady = 1'b0; ifB.MDRout = 1'b1; ifB.Rin = 4'b1000;
        tick();
        checkOutput("b.view_top", ifB.RegView, 64'hBEEF_0000_0000_0000);
        ifB.MDRout = 1'b0; ifB.ExtOut = 1'b1; ifB.ExtIn = 16'h1234; ifB.Rin = 4'b0001;
        tick();
        checkOutput("b.view_r0", ifB.RegView, 64'hBEEF_0000_0000_1234);
        ifB.Rin = '0; ifB.Rout = 4'b1000;
        #1;
        checkOutput("b.bus_r3", ifB.BusMuxOut, 16'hBEEF);
        clearInputs();
        tick();

        $display("[TB] randomized against model");
        doClear("rand_start");
        for (int c = 0; c < 600; c++) begin
            int r;
            ifA.Rin = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            r = $urandom_range(0, 5);
            if (r <= 3)      ifA.Rout = N'(1) << $urandom_range(0, N - 1);
            else if (r == 4) ifA.Rout = '0;
            else             ifA.Rout = (N'(1) << $urandom_range(0, N - 1)) | (N'(1) << $urandom_range(0, N - 1));
            if (r <= 3 && $urandom_range(0, 1) == 0) ifA.Rout = '0;
            ifA.MDRout   = ($urandom_range(0, 3) == 0);
            ifA.ExtOut   = ($urandom_range(0, 3) == 0);
            ifA.ExtIn    = $urandom;
            ifA.MDRin    = ($urandom_range(0, 2) == 0);
            ifA.Read     = ($urandom_range(0, 1) == 0);
            ifA.Mdatain  = $urandom;
            ifA.MemReady = (c >= 200 && c < 400) ? ($urandom_range(0, 24) == 0)
                                                 : ($urandom_range(0, 2) == 0);
            #1;
            checkOutput("rand.bus_comb", ifA.BusMuxOut, modelBus());
            tick();
            checkModel("rand");
            if (c == 450) begin
                doClear("rand_mid");
            end
        end
        clearInputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
